// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD capture path and its framebuffer.
package lcd_pkg;

  localparam int LCD_W          = 160;
  localparam int LCD_H          = 144;
  localparam int BYTES_PER_LINE = LCD_W / 4;
  localparam int FB_BYTES       = BYTES_PER_LINE * LCD_H;
  localparam int FB_AW          = 13;

  // One framebuffer write: byte address plus four packed 2-bit pixels.
  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [7:0]       data;
  } fb_entry_t;

  localparam int FB_ENTRY_W = $bits(fb_entry_t);

endpackage

// File: rtl/lcd_capture_if.sv
// Framebuffer write port: head-of-queue address/data with a req/ack handshake.
interface lcd_capture_if;
  import lcd_pkg::*;

  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_data;
  logic             fb_req;
  logic             fb_ack;

  // The capture block drives the request side.
  modport master (output fb_addr, output fb_data, output fb_req, input fb_ack);
  // The framebuffer accepts the head entry.
  modport slave  (input fb_addr, input fb_data, input fb_req, output fb_ack);

endinterface

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pops only when data exists; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1'b1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1'b1);
        2'b01:   count <= count - CW'(1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_capture.sv
// Captures the LCD pixel stream, packs four 2-bit pixels per byte and queues
// {address, byte} pairs for the framebuffer write port.
module lcd_capture
  import lcd_pkg::*;
#(
  parameter int H_PIXELS   = LCD_W,
  parameter int V_LINES    = LCD_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    pixel_data,
  input  logic          pixel_latch,
  input  logic          hsync,
  input  logic          vsync,
  lcd_capture_if.master fb,
  output logic          frame_done,
  output logic          line_err,
  output logic          overrun,
  input  logic          status_clr
);

  localparam int XW  = $clog2(H_PIXELS + 1);
  localparam int YW  = $clog2(V_LINES + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BPL = H_PIXELS / 4;
  localparam logic [XW-1:0]    X_END     = XW'(H_PIXELS);
  localparam logic [YW-1:0]    Y_END     = YW'(V_LINES);
  localparam logic [FB_AW-1:0] LINE_STEP = FB_AW'(BPL);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(BPL * V_LINES - 1);

  logic [XW-1:0]    x, x_beam, x_next;
  logic [YW-1:0]    y, y_beam, y_next;
  logic [FB_AW-1:0] line_base, base_beam, base_next;
  logic [5:0]       pack, pack_beam, pack_next;

  fb_entry_t        push_entry;
  fb_entry_t        head_entry;
  logic             push;
  logic             line_err_set;
  logic             overrun_set;
  logic             pop_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Beam/packer next state: vsync rebases first, then the pixel, then hsync.
  always_comb begin
    x_beam    = x;
    y_beam    = y;
    base_beam = line_base;
    pack_beam = pack;
    if (vsync) begin
      x_beam    = '0;
      y_beam    = '0;
      base_beam = '0;
      pack_beam = '0;
    end else begin
      x_beam    = x;
      y_beam    = y;
      base_beam = line_base;
      pack_beam = pack;
    end

    x_next       = x_beam;
    y_next       = y_beam;
    base_next    = base_beam;
    pack_next    = pack_beam;
    push         = 1'b0;
    push_entry   = '0;
    line_err_set = 1'b0;

    if (pixel_latch && (x_beam < X_END) && (y_beam < Y_END)) begin
      pack_next = {pack_beam[3:0], pixel_data};
      x_next    = x_beam + XW'(1'b1);
      if (x_beam[1:0] == 2'b11) begin
        push            = 1'b1;
        push_entry.addr = base_beam + FB_AW'(x_beam[XW-1:2]);
        push_entry.data = {pack_beam, pixel_data};
      end else begin
        push = 1'b0;
      end
    end else begin
      x_next = x_beam;
    end

    if (hsync && !vsync) begin
      line_err_set = (y_beam < Y_END) && (x_next != X_END);
      x_next       = '0;
      pack_next    = '0;
      if (y_beam < Y_END) begin
        y_next    = y_beam + YW'(1'b1);
        base_next = base_beam + LINE_STEP;
      end else begin
        y_next    = y_beam;
        base_next = base_beam;
      end
    end else begin
      line_err_set = 1'b0;
    end
  end

  // A push into a full FIFO is lost unless the framebuffer pops in the same cycle.
  always_comb begin
    overrun_set = push && fifo_full && !fb.fb_ack;
    pop_valid   = fb.fb_ack && (fifo_count != '0);
  end

  // Beam counters and the partial-byte shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      pack      <= '0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      line_base <= base_next;
      pack      <= pack_next;
    end
  end

  // Sticky status flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (line_err_set) begin
        line_err <= 1'b1;
      end else if (status_clr) begin
        line_err <= 1'b0;
      end else begin
        line_err <= line_err;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (status_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Pulse once the final byte of the frame has been accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop_valid && (head_entry.addr == LAST_ADDR);
    end
  end

  sync_fifo #(
    .WIDTH (FB_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (fb.fb_ack),
    .din     (push_entry),
    .dout    (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fb.fb_req  = !fifo_empty;
  assign fb.fb_addr = head_entry.addr;
  assign fb.fb_data = head_entry.data;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture with a pixel-level reference model.
module tb_lcd_capture;
  import lcd_pkg::*;

  localparam int H   = 160;
  localparam int V   = 144;
  localparam int D   = 4;
  localparam int BPL = H / 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pixel_data = 2'd0;
  logic       pixel_latch = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       status_clr = 1'b0;
  logic       frame_done;
  logic       line_err;
  logic       overrun;

  lcd_capture_if fb_bus ();

  lcd_capture #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(D)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_latch (pixel_latch),
    .hsync       (hsync),
    .vsync       (vsync),
    .fb          (fb_bus),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .overrun     (overrun),
    .status_clr  (status_clr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beam position in plain integers, bytes built from a
  // four-entry pixel array, FIFO as a bounded queue.
  int         mx, my;
  logic [1:0] mpix [4];
  logic [20:0] mq [$];
  logic [20:0] m_ent, m_head;
  logic       m_le = 1'b0, m_ov = 1'b0, m_fd = 1'b0;
  logic       m_pop, m_push, m_le_set, m_ov_set;

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (reset_n !== 1'b1) begin
        mx = 0; my = 0; mq.delete();
        m_le = 1'b0; m_ov = 1'b0; m_fd = 1'b0;
      end else begin
        m_pop = (fb_bus.fb_ack === 1'b1) && (mq.size() > 0);
        m_fd = 1'b0;
        if (m_pop) begin
          m_head = mq.pop_front();
          if (int'(m_head[20:8]) == BPL * V - 1) m_fd = 1'b1;
        end
        m_push = 1'b0; m_le_set = 1'b0; m_ov_set = 1'b0;
        if (vsync) begin mx = 0; my = 0; end
        if (pixel_latch && mx < H && my < V) begin
          mpix[mx % 4] = pixel_data;
          if (mx % 4 == 3) begin
            m_push = 1'b1;
            m_ent = {13'(my * BPL + mx / 4), mpix[0], mpix[1], mpix[2], mpix[3]};
          end
          mx++;
        end
        if (hsync && !vsync) begin
          if (my < V && mx != H) m_le_set = 1'b1;
          mx = 0;
          if (my < V) my++;
        end
        if (m_push) begin
          if (mq.size() < D) mq.push_back(m_ent);
          else m_ov_set = 1'b1;
        end
        if (status_clr) begin m_le = 1'b0; m_ov = 1'b0; end
        if (m_le_set) m_le = 1'b1;
        if (m_ov_set) m_ov = 1'b1;
      end
    end
  end

  // Accepted writes as seen on the port, for the literal end-of-test checks.
  logic [12:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          fd_count = 0;

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("fb_req", {31'd0, fb_bus.fb_req}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("fb_addr", {19'd0, fb_bus.fb_addr}, {19'd0, mq[0][20:8]});
        chk("fb_data", {24'd0, fb_bus.fb_data}, {24'd0, mq[0][7:0]});
      end
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      chk("line_err", {31'd0, line_err}, {31'd0, m_le});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if (reset_n === 1'b1 && fb_bus.fb_req === 1'b1 && fb_bus.fb_ack === 1'b1) begin
        log_addr.push_back(fb_bus.fb_addr);
        log_data.push_back(fb_bus.fb_data);
      end
      if (frame_done === 1'b1) fd_count++;
    end
  end

  task automatic cyc(input logic lat, input logic [1:0] pd, input logic hs, input logic vs);
    pixel_latch = lat; pixel_data = pd; hsync = hs; vsync = vs;
    @(posedge clock); #1;
    pixel_latch = 1'b0; hsync = 1'b0; vsync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete();
  endtask

  logic [7:0] exp_bytes [5];
  int bad, n3, has159;

  initial begin
    exp_bytes[0] = 8'h1B; exp_bytes[1] = 8'h4E; exp_bytes[2] = 8'hB1;
    exp_bytes[3] = 8'hE4; exp_bytes[4] = 8'h1B;
    fb_bus.fb_ack = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req", {31'd0, fb_bus.fb_req}, 32'd0);
    chk("rst_addr", {19'd0, fb_bus.fb_addr}, 32'd0);
    chk("rst_data", {24'd0, fb_bus.fb_data}, 32'd0);
    chk("rst_flags", {29'd0, frame_done, line_err, overrun}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Full frame, shade = x%4, ack held high
    clear_log(); fd_count = 0;
    fb_bus.fb_ack = 1'b1;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        cyc(1'b1, 2'(xx % 4), 1'b0, 1'b0);
        if (yy == 0 && xx == 3) begin
          chk("lat_req", {31'd0, fb_bus.fb_req}, 32'd1);
          chk("lat_byte", {11'd0, fb_bus.fb_addr, fb_bus.fb_data}, {11'd0, 13'd0, 8'h1B});
        end
      end
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
    end
    idle(8);
    chk("frame_writes", log_addr.size(), 32'd5760);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (int'(log_addr[i]) != i || log_data[i] != 8'h1B) bad++;
    chk("frame_seq", bad, 32'd0);
    chk("frame_done_cnt", fd_count, 32'd1);
    chk("frame_flags", {30'd0, line_err, overrun}, 32'd0);

    // Short line 3
    clear_log();
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < H; xx++) cyc(1'b1, 2'(xx % 4), 1'b0, 1'b0);
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
    end
    for (int xx = 0; xx < 158; xx++) cyc(1'b1, 2'(xx % 4), 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    chk("short_line_err", {31'd0, line_err}, 32'd1);
    idle(4);
    n3 = 0; has159 = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i] >= 13'd120 && log_addr[i] <= 13'd158) n3++;
      if (log_addr[i] == 13'd159) has159++;
    end
    chk("short_line_bytes", n3, 32'd39);
    chk("short_line_partial", has159, 32'd0);
    status_clr = 1'b1; idle(1); status_clr = 1'b0;
    chk("clr_line_err", {31'd0, line_err}, 32'd0);

    // Ack low, six bytes into a four-deep FIFO
    clear_log();
    fb_bus.fb_ack = 1'b0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) cyc(1'b1, 2'((i % 4) ^ ((i / 4) % 4)), 1'b0, 1'b0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_head", {19'd0, fb_bus.fb_addr}, 32'd0);
    fb_bus.fb_ack = 1'b1;
    idle(6);
    chk("ovr_writes", log_addr.size(), 32'd4);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (int'(log_addr[i]) != i || log_data[i] != exp_bytes[i]) bad++;
    chk("ovr_order", bad, 32'd0);
    status_clr = 1'b1; idle(1); status_clr = 1'b0;
    chk("clr_overrun", {31'd0, overrun}, 32'd0);

    // Push into full FIFO with a same-cycle ack
    clear_log();
    fb_bus.fb_ack = 1'b0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) fb_bus.fb_ack = 1'b1;
      cyc(1'b1, 2'((i % 4) ^ ((i / 4) % 4)), 1'b0, 1'b0);
      fb_bus.fb_ack = 1'b0;
    end
    chk("full_pushpop_ovr", {31'd0, overrun}, 32'd0);
    fb_bus.fb_ack = 1'b1;
    idle(6);
    chk("full_pushpop_writes", log_addr.size(), 32'd5);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (int'(log_addr[i]) != i || log_data[i] != exp_bytes[i]) bad++;
    chk("full_pushpop_order", bad, 32'd0);

    // vsync discards a partial byte; same-cycle pixel lands at x=0
    clear_log();
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b1);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    idle(4);
    chk("vs_writes", log_addr.size(), 32'd1);
    if (log_addr.size() > 0)
      chk("vs_byte", {11'd0, log_addr[0], log_data[0]}, {11'd0, 13'd0, 8'hE4});

    // Reset with three bytes queued and a flag set
    fb_bus.fb_ack = 1'b0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
    chk("pre_rst_state", {30'd0, fb_bus.fb_req, line_err}, 32'd3);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, fb_bus.fb_req}, 32'd0);
    chk("mid_rst_flags", {29'd0, frame_done, line_err, overrun}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    clear_log();
    fb_bus.fb_ack = 1'b1;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 1'b0, 1'b0);
    idle(3);
    chk("post_rst_writes", log_addr.size(), 32'd1);
    if (log_addr.size() > 0)
      chk("post_rst_byte", {11'd0, log_addr[0], log_data[0]}, {11'd0, 13'd0, 8'h1B});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
